// File: rtl/chip2chip_defs.sv
// Shared Chip2Chip link definitions: top-level state codes, master FSM encoding, default link width.
// Pure constants, no latency or backpressure of its own.
package chip2chip_defs;
    localparam int DATA_W_DEF = 3;

    localparam logic [1:0] TS_IDLE = 2'b00;
    localparam logic [1:0] TS_XFER = 2'b01;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_REL   = 3'd4;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one off-chip level signal; 2-cycle pin-to-output latency.
// No backpressure: the level is sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/master_control.sv
// Chip2Chip master link controller: 4-phase request/ack, data setup, valid until done, release.
// Registered outputs; ack/done seen 2 cycles after the pins; starts are dropped unless idle in XFER.
module master_control
    import chip2chip_defs::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SETUP_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        top_state,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ack,
    input  logic              done,
    output logic              request,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              notice_master,
    output logic              timeout_err
);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_data_out;
    logic              r_request;
    logic              r_valid;
    logic              r_notice;
    logic              r_timeout;

    logic              w_ack_s;
    logic              w_done_s;
    logic              w_abort;
    logic              w_wait;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_cnt_next;

    sync_2ff u_sync_ack  (.clk(clk), .i_rst(rst_n), .i_d(ack),  .o_q(w_ack_s));
    sync_2ff u_sync_done (.clk(clk), .i_rst(rst_n), .i_d(done), .o_q(w_done_s));

    assign w_abort    = (r_state != ST_IDLE) && (top_state != TS_XFER);
    assign w_wait     = (r_state == ST_REQ) || (r_state == ST_DATA) || (r_state == ST_REL);
    assign w_timeout  = w_wait && (r_cnt == TIMEOUT_LAST);
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // rst_n is active-high: the enclosing top feeds the inverted board reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_data_out <= '0;
            r_request  <= 1'b0;
            r_valid    <= 1'b0;
            r_notice   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_notice  <= 1'b0;
            r_timeout <= 1'b0;
            if (w_abort || w_timeout) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_data_out <= '0;
                r_request  <= 1'b0;
                r_valid    <= 1'b0;
                r_timeout  <= !w_abort;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // The notice cycle still belongs to the finished transfer.
                        if (start && (top_state == TS_XFER) && !r_notice) begin
                            r_data    <= data_in;
                            r_request <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (w_ack_s) begin
                            r_state    <= ST_SETUP;
                            r_cnt      <= '0;
                            r_data_out <= r_data;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    ST_SETUP: begin
                        if (r_cnt == SETUP_LAST) begin
                            r_state <= ST_DATA;
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    ST_DATA: begin
                        if (w_done_s) begin
                            r_state    <= ST_REL;
                            r_request  <= 1'b0;
                            r_valid    <= 1'b0;
                            r_data_out <= '0;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    ST_REL: begin
                        if (!w_ack_s && !w_done_s) begin
                            r_state  <= ST_IDLE;
                            r_notice <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign request       = r_request;
    assign valid         = r_valid;
    assign data_out      = r_data_out;
    assign busy          = (r_state != ST_IDLE);
    assign notice_master = r_notice;
    assign timeout_err   = r_timeout;
endmodule

// File: tb/tb_master_control.sv
// Self-checking bench for master_control: transfers described by event cycles, outputs predicted per cycle.
module tb_master_control;
    import chip2chip_defs::*;

    localparam int SETUP_CYC   = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int NEVER       = 1 << 28;
    localparam int M_NORMAL    = 0;
    localparam int M_TIMEOUT   = 1;
    localparam int M_ABORT     = 2;
    localparam int M_RESET     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] top_state = TS_XFER;
    logic       start = 1'b0;
    logic [2:0] data_in = 3'b000;
    logic       ack = 1'b0;
    logic       done = 1'b0;
    logic       request, valid, busy, notice_master, timeout_err;
    logic [2:0] data_out;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;

    master_control #(
        .DATA_W(3), .SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .top_state(top_state), .start(start), .data_in(data_in),
        .ack(ack), .done(done), .request(request), .valid(valid), .data_out(data_out),
        .busy(busy), .notice_master(notice_master), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"},   request, 0);
        chk({tag, "_val"},   valid, 0);
        chk({tag, "_dat"},   data_out, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_notc"},  notice_master, 0);
        chk({tag, "_err"},   timeout_err, 0);
    endtask

    // One transfer, expressed as the cycle each pin event lands; outputs are predicted from those cycles.
    // For M_ABORT, done_dly is the abort offset after valid rises.
    task automatic run_xfer(input logic [2:0] w, input int ack_dly, input int done_dly,
                            input int rel_dly, input int mode, input bit extra);
        int k0, s, a, v, d, r, k, errc, last;
        @(negedge clk);
        k0 = cyc;
        s = k0 + 1;
        a = NEVER; v = NEVER; d = NEVER; r = NEVER; k = NEVER; errc = NEVER;
        if (mode == M_TIMEOUT) begin
            k = s + TIMEOUT_CYC;
            errc = k;
            last = k + 2;
        end else begin
            a = s + ack_dly + 1;
            v = a + 2 + SETUP_CYC;
            if (mode == M_NORMAL) begin
                d = v + done_dly + 1;
                r = d + 2 + rel_dly + 1;
                last = r + 4;
            end else if (mode == M_ABORT) begin
                k = v + done_dly + 1;
                last = k + 2;
            end else begin
                k = a + 4;
                last = k + 2;
            end
        end
        for (int c = k0; c <= last; c++) begin
            if (c != k0) @(negedge clk);
            chk("request", request, (c >= s && c < d + 2 && c < k));
            chk("valid",   valid,   (c >= v && c < d + 2 && c < k));
            chk("data_out", data_out, (c >= a + 2 && c < d + 2 && c < k) ? w : 3'b000);
            chk("busy",    busy,    (c >= s && c < r + 2 && c < k));
            chk("notice",  notice_master, (c == r + 2));
            chk("timeout", timeout_err,   (c == errc));
            start     = (c == k0) || (extra && c > s && c <= r + 2 &&
                         ($urandom_range(0, 2) == 0 || c == r + 2));
            data_in   = (c == k0) ? w : 3'($urandom);
            ack       = (c >= a - 1) && (c < r - 1) && !(mode == M_RESET && c >= k - 1);
            done      = (c >= d - 1) && (c < r - 1);
            top_state = (mode == M_ABORT && c >= k - 1) ? TS_IDLE : TS_XFER;
            rst_n     = (mode == M_RESET && c == k - 1);
        end
        @(negedge clk);
        start = 1'b0; ack = 1'b0; done = 1'b0; top_state = TS_XFER; rst_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("post_reset");

        run_xfer(3'b101, 3, 5, 2, M_NORMAL, 1'b0);
        run_xfer(3'b011, 0, 0, 0, M_TIMEOUT, 1'b0);
        run_xfer(3'b110, 2, 1, 0, M_ABORT, 1'b0);

        // Start while the top FSM is not in XFER must be ignored.
        @(negedge clk);
        top_state = TS_IDLE; start = 1'b1; data_in = 3'b110;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("top_idle_start");
        end
        top_state = TS_XFER;

        run_xfer(3'b010, 4, 3, 1, M_NORMAL, 1'b1);
        run_xfer(3'b111, 1, 0, 0, M_RESET, 1'b0);
        run_xfer(3'b100, 2, 2, 2, M_NORMAL, 1'b0);
        run_xfer(3'b000, 0, 0, 0, M_NORMAL, 1'b0);
        run_xfer(3'b111, 0, 0, 0, M_NORMAL, 1'b0);

        for (int i = 0; i < 16; i++) begin
            int m;
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : M_NORMAL;
            run_xfer(3'($urandom), $urandom_range(0, 10),
                     (m == M_ABORT) ? $urandom_range(0, 3) : $urandom_range(0, 10),
                     $urandom_range(0, 10), m, (m == M_NORMAL) ? 1'($urandom) : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
